// File: rtl/vend_session_fsm.sv
`default_nettype none
// +-------------------------------------------------------------------------------------+
// | vend_session_fsm: vending front-end session FSM (code/cash entry, handshakes, BCD). |
// | Rev 1.0                                                                             |
// +-------------------------------------------------------------------------------------+
module vend_session_fsm #(
  parameter int N_DIGITS    = 4,
  parameter int CODE_DIGITS = 2,
  parameter int CODE_HI_MAX = 12,
  parameter int BIN_W       = 14,
  parameter int TIMEOUT_CYC = 30000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_DIGITS-1:0]      inc,
  input  logic                     confirm,
  input  logic                     cancel,
  output logic [4*CODE_DIGITS-1:0] code,
  output logic                     code_req,
  input  logic                     code_ok,
  input  logic                     code_bad,
  input  logic [BIN_W-1:0]         price,
  output logic [BIN_W-1:0]         cash,
  output logic                     cash_req,
  input  logic                     cash_ok,
  input  logic                     cash_bad,
  input  logic [BIN_W-1:0]         refund,
  output logic [4*N_DIGITS-1:0]    disp,
  output logic [2:0]               state_o,
  output logic                     err
);

  function automatic int unsigned pow10(input int n);
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  localparam logic [BIN_W-1:0] DISP_LIMIT = BIN_W'(pow10(N_DIGITS));
  localparam int CONV_CW = $clog2(BIN_W + 1);
  localparam int TMO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CODE_WAIT = 3'd1,
    S_PRICE     = 3'd2,
    S_CASH      = 3'd3,
    S_CASH_WAIT = 3'd4,
    S_RESULT    = 3'd5,
    S_ERROR     = 3'd6,
    S_CONV      = 3'd7
  } state_t;

  state_t                   state, state_nxt, conv_tgt, conv_tgt_nxt;
  logic [N_DIGITS-1:0][3:0] dig, dig_nxt;
  logic [4*CODE_DIGITS-1:0] code_nxt;
  logic                     code_req_nxt, cash_req_nxt;
  logic [BIN_W-1:0]         cash_nxt, conv_bin, conv_bin_nxt, conv_val;
  logic [4*N_DIGITS-1:0]    bcd, bcd_nxt, bcd_shift;
  logic [CONV_CW-1:0]       conv_cnt, conv_cnt_nxt;
  logic                     conv_sat, conv_sat_nxt, conv_abort, conv_abort_nxt, conv_load;
  logic [TMO_W-1:0]         tmo_cnt, tmo_cnt_nxt;
  logic                     confirm_q, conf_rise, tmo_hit, abort;

  function automatic logic [3:0] wrap_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Horner evaluation of the decimal entry field.
  function automatic logic [BIN_W-1:0] digits_to_bin(input logic [N_DIGITS-1:0][3:0] d);
    logic [BIN_W-1:0] acc;
    acc = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) acc = acc * BIN_W'(10) + BIN_W'(d[i]);
    return acc;
  endfunction

  assign conf_rise = confirm & ~confirm_q;
  assign tmo_hit   = (TIMEOUT_CYC != 0) && (state != S_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
  assign abort     = cancel | tmo_hit;

  // One double-dabble step: add-3 adjust, then shift in the next binary MSB.
  always_comb begin
    bcd_shift = bcd;
    for (int i = 0; i < N_DIGITS; i++)
      if (bcd_shift[4*i +: 4] >= 4'd5) bcd_shift[4*i +: 4] = bcd_shift[4*i +: 4] + 4'd3;
    bcd_shift = {bcd_shift[4*N_DIGITS-2:0], conv_bin[BIN_W-1]};
  end

  always_comb begin
    state_nxt      = state;
    conv_tgt_nxt   = conv_tgt;
    dig_nxt        = dig;
    code_nxt       = code;
    code_req_nxt   = 1'b0;
    cash_nxt       = cash;
    cash_req_nxt   = 1'b0;
    conv_bin_nxt   = conv_bin;
    bcd_nxt        = bcd;
    conv_cnt_nxt   = conv_cnt;
    conv_sat_nxt   = conv_sat;
    conv_abort_nxt = conv_abort;
    conv_load      = 1'b0;
    conv_val       = price;
    case (state)
      S_IDLE: begin
        if (cancel) begin
          dig_nxt = '0;
        end else if (conf_rise) begin
          code_nxt     = dig[CODE_DIGITS-1:0];
          code_req_nxt = 1'b1;
          dig_nxt      = '0;
          state_nxt    = S_CODE_WAIT;
        end else begin
          for (int i = 0; i < CODE_DIGITS; i++)
            if (inc[i]) dig_nxt[i] = wrap_inc(dig[i], (i == CODE_DIGITS - 1) ? 4'(CODE_HI_MAX) : 4'd9);
        end
      end
      S_CODE_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dig_nxt   = '0;
        end else if (code_bad) begin
          state_nxt = S_ERROR;
          dig_nxt   = '0;
        end else if (code_ok) begin
          conv_load    = 1'b1;
          conv_val     = price;
          conv_tgt_nxt = S_PRICE;
          state_nxt    = S_CONV;
        end
      end
      S_CONV: begin
        conv_bin_nxt   = conv_bin << 1;
        bcd_nxt        = bcd_shift;
        conv_cnt_nxt   = conv_cnt + 1'b1;
        conv_abort_nxt = conv_abort | abort;
        if (conv_cnt == CONV_CW'(BIN_W - 1)) begin
          if (conv_abort | abort) begin
            state_nxt = S_IDLE;
            dig_nxt   = '0;
          end else begin
            state_nxt = conv_tgt;
            dig_nxt   = conv_sat ? {N_DIGITS{4'd9}} : bcd_shift;
          end
        end
      end
      S_PRICE: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dig_nxt   = '0;
        end else if (conf_rise) begin
          state_nxt = S_CASH;
          dig_nxt   = '0;
        end
      end
      S_CASH: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dig_nxt   = '0;
        end else if (conf_rise) begin
          cash_nxt     = digits_to_bin(dig);
          cash_req_nxt = 1'b1;
          state_nxt    = S_CASH_WAIT;
        end else begin
          for (int i = 0; i < N_DIGITS; i++)
            if (inc[i]) dig_nxt[i] = wrap_inc(dig[i], 4'd9);
        end
      end
      S_CASH_WAIT: begin
        if (abort) begin
          state_nxt = S_IDLE;
          dig_nxt   = '0;
        end else if (cash_bad) begin
          state_nxt = S_ERROR;
          dig_nxt   = '0;
        end else if (cash_ok) begin
          conv_load    = 1'b1;
          conv_val     = refund;
          conv_tgt_nxt = S_RESULT;
          state_nxt    = S_CONV;
        end
      end
      S_RESULT, S_ERROR: begin
        if (abort || conf_rise) begin
          state_nxt = S_IDLE;
          dig_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        dig_nxt   = '0;
      end
    endcase
    if (conv_load) begin
      conv_bin_nxt   = conv_val;
      bcd_nxt        = '0;
      conv_cnt_nxt   = '0;
      conv_sat_nxt   = (conv_val >= DISP_LIMIT);
      conv_abort_nxt = 1'b0;
    end
  end

  // Inactivity timer restarts on any user activity or state change.
  always_comb begin
    if (state == S_IDLE || state_nxt != state || inc != '0 || conf_rise) tmo_cnt_nxt = '0;
    else tmo_cnt_nxt = tmo_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    confirm_q <= confirm;
    if (reset) begin
      state      <= S_IDLE;
      conv_tgt   <= S_PRICE;
      dig        <= '0;
      code       <= '0;
      code_req   <= 1'b0;
      cash       <= '0;
      cash_req   <= 1'b0;
      conv_bin   <= '0;
      bcd        <= '0;
      conv_cnt   <= '0;
      conv_sat   <= 1'b0;
      conv_abort <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      conv_tgt   <= conv_tgt_nxt;
      dig        <= dig_nxt;
      code       <= code_nxt;
      code_req   <= code_req_nxt;
      cash       <= cash_nxt;
      cash_req   <= cash_req_nxt;
      conv_bin   <= conv_bin_nxt;
      bcd        <= bcd_nxt;
      conv_cnt   <= conv_cnt_nxt;
      conv_sat   <= conv_sat_nxt;
      conv_abort <= conv_abort_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
    end
  end

  assign disp    = dig;
  assign state_o = state;
  assign err     = (state == S_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_vend_session_fsm.sv
`default_nettype none
// tb_vend_session_fsm: directed and randomized sessions against an arithmetic reference model.
module tb_vend_session_fsm;
  localparam int N_DIGITS    = 4;
  localparam int CODE_DIGITS = 2;
  localparam int CODE_HI_MAX = 12;
  localparam int BIN_W       = 14;
  localparam int TIMEOUT_CYC = 16;

  logic clk = 1'b0;
  logic reset, confirm, cancel, code_ok, code_bad, cash_ok, cash_bad;
  logic [N_DIGITS-1:0]      inc;
  logic [BIN_W-1:0]         price, refund, cash;
  logic [4*CODE_DIGITS-1:0] code;
  logic                     code_req, cash_req, err;
  logic [4*N_DIGITS-1:0]    disp;
  logic [2:0]               state_o;

  int n_cmp = 0;
  int n_bad = 0;
  int ent [N_DIGITS];

  always #5 clk = ~clk;

  vend_session_fsm #(
    .N_DIGITS(N_DIGITS), .CODE_DIGITS(CODE_DIGITS), .CODE_HI_MAX(CODE_HI_MAX),
    .BIN_W(BIN_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset(reset), .inc(inc), .confirm(confirm), .cancel(cancel),
    .code(code), .code_req(code_req), .code_ok(code_ok), .code_bad(code_bad), .price(price),
    .cash(cash), .cash_req(cash_req), .cash_ok(cash_ok), .cash_bad(cash_bad), .refund(refund),
    .disp(disp), .state_o(state_o), .err(err)
  );

  // Decimal display expected for a value, saturating at 9999.
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'h9999;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_inc(input logic [3:0] m);
    inc = m; tick(); inc = '0;
  endtask

  task automatic pulse_cancel();
    cancel = 1'b1; tick(); cancel = 1'b0;
  endtask

  task automatic press_confirm();
    confirm = 1'b1; tick(); confirm = 1'b0;
  endtask

  task automatic wait_conv(output int n);
    n = 0;
    while (state_o == 3'd7 && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic go_code_wait();
    press_confirm(); tick();
  endtask

  task automatic go_price(input int p, output int n);
    go_code_wait();
    price = 14'(p); code_ok = 1'b1; tick(); code_ok = 1'b0;
    wait_conv(n);
  endtask

  task automatic test_reset();
    reset = 1'b1; confirm = 1'b1;
    repeat (3) tick();
    reset = 1'b0; tick();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_cmp++; if (disp !== 16'h0) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", disp); end
    n_cmp++; if (code !== 8'h0 || cash !== 14'd0) begin n_bad++; $display("FAIL reset_code_cash: got %h/%0d want 0/0", code, cash); end
    n_cmp++; if ({code_req, cash_req, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {code_req, cash_req, err}); end
    tick();
    n_cmp++; if (state_o !== 3'd0 || code_req !== 1'b0) begin n_bad++; $display("FAIL held_confirm: got state %0d req %b want 0 0", state_o, code_req); end
    confirm = 1'b0; tick();
  endtask

  task automatic test_code_entry();
    repeat (3) pulse_inc(4'b0001);
    repeat (12) pulse_inc(4'b0010);
    n_cmp++; if (disp !== 16'h00C3) begin n_bad++; $display("FAIL code_hi_max: got %h want 00c3", disp); end
    pulse_inc(4'b0010);
    n_cmp++; if (disp !== 16'h0003) begin n_bad++; $display("FAIL code_wrap: got %h want 0003", disp); end
    press_confirm();
    n_cmp++; if (code_req !== 1'b1 || code !== 8'h03) begin n_bad++; $display("FAIL code_latch: got req %b code %h want 1 03", code_req, code); end
    n_cmp++; if (state_o !== 3'd1 || disp !== 16'h0) begin n_bad++; $display("FAIL code_wait: got state %0d disp %h want 1 0000", state_o, disp); end
    tick();
    n_cmp++; if (code_req !== 1'b0) begin n_bad++; $display("FAIL code_req_width: got %b want 0", code_req); end
    pulse_cancel();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL cancel_code_wait: got %0d want 0", state_o); end
  endtask

  task automatic test_inc_with_confirm();
    repeat (2) pulse_inc(4'b0001);
    inc = 4'b0001; confirm = 1'b1; tick(); inc = '0; confirm = 1'b0;
    n_cmp++; if (code !== 8'h02 || code_req !== 1'b1) begin n_bad++; $display("FAIL inc_conf_same: got code %h req %b want 02 1", code, code_req); end
    n_cmp++; if (disp !== 16'h0) begin n_bad++; $display("FAIL inc_conf_disp: got %h want 0000", disp); end
    tick(); pulse_cancel();
  endtask

  task automatic test_idle_cancel();
    repeat (5) pulse_inc(4'b0011);
    pulse_inc(4'b1100);
    n_cmp++; if (disp !== 16'h0055) begin n_bad++; $display("FAIL idle_entry: got %h want 0055", disp); end
    pulse_cancel();
    n_cmp++; if (disp !== 16'h0 || state_o !== 3'd0) begin n_bad++; $display("FAIL idle_cancel: got disp %h state %0d want 0000 0", disp, state_o); end
  endtask

  task automatic test_price_cash_refund();
    int n;
    go_code_wait();
    price = 14'd275; code_ok = 1'b1; tick(); code_ok = 1'b0;
    n_cmp++; if (state_o !== 3'd7 || disp !== 16'h0) begin n_bad++; $display("FAIL conv_entry: got state %0d disp %h want 7 0000", state_o, disp); end
    wait_conv(n);
    n_cmp++; if (n !== BIN_W) begin n_bad++; $display("FAIL conv_cycles: got %0d want %0d", n, BIN_W); end
    n_cmp++; if (state_o !== 3'd2 || disp !== 16'h0275) begin n_bad++; $display("FAIL price_disp: got state %0d disp %h want 2 0275", state_o, disp); end
    press_confirm(); tick();
    repeat (5) pulse_inc(4'b0001);
    repeat (3) pulse_inc(4'b0100);
    n_cmp++; if (disp !== 16'h0305) begin n_bad++; $display("FAIL cash_entry: got %h want 0305", disp); end
    press_confirm();
    n_cmp++; if (cash_req !== 1'b1 || cash !== 14'd305) begin n_bad++; $display("FAIL cash_value: got req %b cash %0d want 1 305", cash_req, cash); end
    tick();
    refund = 14'd30; cash_ok = 1'b1; tick(); cash_ok = 1'b0;
    wait_conv(n);
    n_cmp++; if (state_o !== 3'd5 || disp !== 16'h0030) begin n_bad++; $display("FAIL refund_disp: got state %0d disp %h want 5 0030", state_o, disp); end
    press_confirm();
    n_cmp++; if (state_o !== 3'd0 || disp !== 16'h0) begin n_bad++; $display("FAIL result_exit: got state %0d disp %h want 0 0000", state_o, disp); end
    tick();
  endtask

  task automatic test_errors();
    int n;
    go_code_wait();
    code_bad = 1'b1; tick(); code_bad = 1'b0;
    n_cmp++; if (state_o !== 3'd6 || err !== 1'b1 || disp !== 16'h0) begin n_bad++; $display("FAIL code_bad: got state %0d err %b disp %h want 6 1 0000", state_o, err, disp); end
    press_confirm();
    n_cmp++; if (state_o !== 3'd0 || err !== 1'b0) begin n_bad++; $display("FAIL error_exit: got state %0d err %b want 0 0", state_o, err); end
    tick();
    go_code_wait();
    code_ok = 1'b1; code_bad = 1'b1; tick(); code_ok = 1'b0; code_bad = 1'b0;
    n_cmp++; if (state_o !== 3'd6) begin n_bad++; $display("FAIL code_bad_wins: got %0d want 6", state_o); end
    press_confirm(); tick();
    go_price(100, n);
    press_confirm(); tick();
    pulse_inc(4'b0001);
    press_confirm(); tick();
    refund = 14'd7; cash_ok = 1'b1; cash_bad = 1'b1; tick(); cash_ok = 1'b0; cash_bad = 1'b0;
    n_cmp++; if (state_o !== 3'd6 || err !== 1'b1 || disp !== 16'h0) begin n_bad++; $display("FAIL cash_bad_wins: got state %0d err %b disp %h want 6 1 0000", state_o, err, disp); end
    press_confirm();
    n_cmp++; if (state_o !== 3'd0) begin n_bad++; $display("FAIL cash_error_exit: got %0d want 0", state_o); end
    tick();
  endtask

  task automatic test_timeout_cancel();
    int n;
    go_price(1234, n);
    n = 0;
    while (state_o == 3'd2 && n < 40) begin
      n++;
      tick();
    end
    n_cmp++; if (n !== TIMEOUT_CYC || state_o !== 3'd0) begin n_bad++; $display("FAIL price_timeout: got %0d cycles state %0d want %0d 0", n, state_o, TIMEOUT_CYC); end
    go_price(50, n);
    press_confirm(); tick();
    repeat (2) pulse_inc(4'b0111);
    n_cmp++; if (disp !== 16'h0222) begin n_bad++; $display("FAIL cash_all_digits: got %h want 0222", disp); end
    pulse_cancel();
    n_cmp++; if (state_o !== 3'd0 || disp !== 16'h0) begin n_bad++; $display("FAIL cash_cancel: got state %0d disp %h want 0 0000", state_o, disp); end
    go_code_wait();
    price = 14'd42; code_ok = 1'b1; tick(); code_ok = 1'b0;
    repeat (3) tick();
    pulse_cancel();
    wait_conv(n);
    n_cmp++; if (n !== BIN_W - 4 || state_o !== 3'd0 || disp !== 16'h0) begin n_bad++; $display("FAIL conv_cancel: got %0d cycles state %0d disp %h want %0d 0 0000", n, state_o, disp, BIN_W - 4); end
  endtask

  task automatic test_reset_handshake();
    int n;
    logic seen;
    go_price(10, n);
    press_confirm(); tick();
    pulse_inc(4'b0010);
    press_confirm(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (cash !== 14'd0 || state_o !== 3'd0) begin n_bad++; $display("FAIL reset_mid: got cash %0d state %0d want 0 0", cash, state_o); end
    refund = 14'd5; price = 14'd9; cash_ok = 1'b1; code_ok = 1'b1; tick(); cash_ok = 1'b0; code_ok = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen = seen | code_req | cash_req | (state_o != 3'd0);
      tick();
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL late_response: got activity %b want 0", seen); end
  endtask

  task automatic test_random_sessions();
    int d0, d1, p, r, n, exp_cash;
    logic [3:0] m;
    for (int it = 0; it < 6; it++) begin
      d0 = 0; d1 = 0;
      for (int k = 0; k < 20; k++) begin
        m = 4'($urandom_range(0, 15));
        if (m[0]) d0 = (d0 + 1) % 10;
        if (m[1]) d1 = (d1 + 1) % (CODE_HI_MAX + 1);
        pulse_inc(m);
      end
      n_cmp++; if (disp !== {8'h00, 4'(d1), 4'(d0)}) begin n_bad++; $display("FAIL rnd_code_disp: got %h want %h", disp, {8'h00, 4'(d1), 4'(d0)}); end
      press_confirm();
      n_cmp++; if (code_req !== 1'b1 || code !== {4'(d1), 4'(d0)}) begin n_bad++; $display("FAIL rnd_code: got req %b code %h want 1 %h", code_req, code, {4'(d1), 4'(d0)}); end
      tick();
      repeat ($urandom_range(0, 3)) tick();
      p = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383)) : int'($urandom_range(0, 9999));
      price = 14'(p); code_ok = 1'b1; tick(); code_ok = 1'b0;
      wait_conv(n);
      n_cmp++; if (n !== BIN_W || state_o !== 3'd2) begin n_bad++; $display("FAIL rnd_price_conv: got %0d cycles state %0d want %0d 2", n, state_o, BIN_W); end
      n_cmp++; if (disp !== to_bcd(p)) begin n_bad++; $display("FAIL rnd_price_disp: got %h want %h (price %0d)", disp, to_bcd(p), p); end
      press_confirm(); tick();
      for (int i = 0; i < N_DIGITS; i++) ent[i] = 0;
      for (int k = 0; k < 20; k++) begin
        m = 4'($urandom_range(0, 15));
        for (int i = 0; i < N_DIGITS; i++) if (m[i]) ent[i] = (ent[i] + 1) % 10;
        pulse_inc(m);
      end
      exp_cash = ent[0] + 10 * ent[1] + 100 * ent[2] + 1000 * ent[3];
      press_confirm();
      n_cmp++; if (cash_req !== 1'b1 || cash !== 14'(exp_cash)) begin n_bad++; $display("FAIL rnd_cash: got req %b cash %0d want 1 %0d", cash_req, cash, exp_cash); end
      tick();
      n_cmp++; if (cash_req !== 1'b0 || code_req !== 1'b0 || state_o !== 3'd4) begin n_bad++; $display("FAIL rnd_cash_wait: got reqs %b%b state %0d want 00 4", code_req, cash_req, state_o); end
      r = int'($urandom_range(0, 9999));
      refund = 14'(r); cash_ok = 1'b1; tick(); cash_ok = 1'b0;
      wait_conv(n);
      n_cmp++; if (state_o !== 3'd5 || disp !== to_bcd(r)) begin n_bad++; $display("FAIL rnd_refund: got state %0d disp %h want 5 %h", state_o, disp, to_bcd(r)); end
      press_confirm();
      n_cmp++; if (state_o !== 3'd0 || disp !== 16'h0) begin n_bad++; $display("FAIL rnd_back_idle: got state %0d disp %h want 0 0000", state_o, disp); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; confirm = 1'b0; cancel = 1'b0; inc = '0;
    code_ok = 1'b0; code_bad = 1'b0; cash_ok = 1'b0; cash_bad = 1'b0;
    price = '0; refund = '0;
    test_reset();
    test_code_entry();
    test_inc_with_confirm();
    test_idle_cancel();
    test_price_cash_refund();
    test_errors();
    test_timeout_cancel();
    test_reset_handshake();
    test_random_sessions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
